// File: rtl/sram_like_ram_bridge.sv
// sram_like_ram_bridge: sram-like CPU bus to async-read/sync-write word RAM, sub-word stores done as read-modify-write
module sram_like_ram_bridge #(
   parameter int ADDR_WIDTH = 16,
   parameter int DELAY = 0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req,
   input  logic                  wr,
   input  logic [1:0]            size,
   input  logic [31:0]           addr,
   input  logic [31:0]           wdata,
   output logic                  addr_ok,
   output logic                  data_ok,
   output logic [31:0]           rdata,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic [31:0]           ram_d,
   input  logic [31:0]           ram_spo
);
   typedef enum logic [2:0] {IDLE, WAIT, ACCESS, WRITE, RESP} state_t;
   localparam logic [7:0] WAIT_LAST = 8'(DELAY > 0 ? DELAY - 1 : 0);
   state_t state, state_nx;
   logic [7:0] cnt;
   logic l_wr;
   logic [1:0] l_size, l_off;
   logic [31:0] l_wdata, merged;
   logic [3:0] strb;
   logic unused_addr;
   assign unused_addr = ^{addr[31:ADDR_WIDTH+2]};
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      addr_ok = 1'b0;
      data_ok = 1'b0;
      ram_we = 1'b0;
      case (state)
         IDLE: begin
            addr_ok = resetn;
            if (req) state_nx = DELAY > 0 ? WAIT : ACCESS;
         end
         WAIT: if (cnt == WAIT_LAST) state_nx = ACCESS;
         ACCESS: state_nx = l_wr ? WRITE : RESP;
         WRITE: begin
            ram_we = 1'b1;
            state_nx = RESP;
         end
         RESP: begin
            data_ok = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   // halfword lanes follow addr[1] only; word stores cover every lane
   assign strb = l_size == 2'd0 ? 4'b0001 << l_off : l_size == 2'd1 ? (l_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign merged[8*i +: 8] = strb[i] ? l_wdata[8*i +: 8] : ram_spo[8*i +: 8];
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         cnt <= '0;
         l_wr <= 1'b0;
         l_size <= '0;
         l_off <= '0;
         l_wdata <= '0;
         rdata <= '0;
         ram_a <= '0;
         ram_d <= '0;
      end else begin
         if (addr_ok && req) begin
            l_wr <= wr;
            l_size <= size;
            l_off <= addr[1:0];
            l_wdata <= wdata;
            ram_a <= addr[ADDR_WIDTH+1:2];
            cnt <= '0;
         end
         if (state == WAIT) cnt <= cnt + 8'd1;
         if (state == ACCESS) begin
            rdata <= l_wr ? '0 : ram_spo;
            if (l_wr) ram_d <= merged;
         end
      end
endmodule

// File: tb/tb_sram_like_ram_bridge.sv
// tb_sram_like_ram_bridge: vector table, corner sequences and random traffic against a byte-lane memory model
module tb_sram_like_ram_bridge;
   localparam int AW = 8;
   typedef struct {
      logic        init_en;
      logic [31:0] init;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [31:0] exp_d;
   } vec_t;
   logic clk = 1'b0;
   logic resetn;
   logic req[2], wr[2], addr_ok[2], data_ok[2], ram_we[2];
   logic [1:0] size[2];
   logic [31:0] addr[2], wdata[2], rdata[2], ram_d[2], ram_spo[2];
   logic [AW-1:0] ram_a[2];
   logic [31:0] mem0[256], mem1[256];
   logic [31:0] ref_mem[2][256];
   vec_t tbl[12];
   int vecs = 0, errs = 0;
   always #5 clk = ~clk;
   sram_like_ram_bridge #(.ADDR_WIDTH(AW), .DELAY(0)) dut0 (
      .clk(clk), .resetn(resetn), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
      .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]),
      .ram_we(ram_we[0]), .ram_a(ram_a[0]), .ram_d(ram_d[0]), .ram_spo(ram_spo[0]));
   sram_like_ram_bridge #(.ADDR_WIDTH(AW), .DELAY(3)) dut1 (
      .clk(clk), .resetn(resetn), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
      .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]),
      .ram_we(ram_we[1]), .ram_a(ram_a[1]), .ram_d(ram_d[1]), .ram_spo(ram_spo[1]));
   always @(posedge clk) begin
      if (ram_we[0]) mem0[ram_a[0]] <= ram_d[0];
      if (ram_we[1]) mem1[ram_a[1]] <= ram_d[1];
   end
   assign ram_spo[0] = mem0[ram_a[0]];
   assign ram_spo[1] = mem1[ram_a[1]];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic poke(input int s, input int i, input logic [31:0] v);
      ref_mem[s][i] = v;
      if (s == 1) mem1[i] <= v;
      else mem0[i] <= v;
   endtask

   // bytes [off, off+n) of the word take the store data
   function automatic logic [31:0] store_model(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] sz, input logic [31:0] a);
      int n, off;
      logic [31:0] r;
      n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      off = sz == 2'd0 ? int'(a % 4) : sz == 2'd1 ? int'(a % 4) / 2 * 2 : 0;
      r = old;
      for (int b = 0; b < 4; b++) if (b >= off && b < off + n) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic txn(input int s, input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic [31:0] exp_d);
      int dl, ok_k, we_n, we_k, busy_ok;
      logic [31:0] rd;
      dl = s == 1 ? 3 : 0;
      ok_k = 0; we_n = 0; we_k = 0; busy_ok = 0; rd = '0;
      @(negedge clk);
      req[s] = 1'b1; wr[s] = w; size[s] = sz; addr[s] = a; wdata[s] = wd;
      chk("addr_ok_idle", 32'(addr_ok[s]), 1);
      @(posedge clk);
      #1;
      req[s] = 1'b0; wr[s] = 1'($urandom); size[s] = 2'($urandom); addr[s] = $urandom; wdata[s] = $urandom;
      for (int k = 1; k <= 40 && ok_k == 0; k++) begin
         @(negedge clk);
         if (addr_ok[s]) busy_ok++;
         if (ram_we[s]) begin
            we_n++;
            we_k = k;
            chk("ram_a_at_we", 32'(ram_a[s]), 32'(8'(a >> 2)));
            chk("ram_d_at_we", ram_d[s], exp_d);
         end
         if (data_ok[s]) begin
            ok_k = k;
            rd = rdata[s];
         end
      end
      chk("data_ok_latency", ok_k, w ? 3 + dl : 2 + dl);
      chk("ram_we_pulses", we_n, 32'(w));
      if (w) chk("ram_we_cycle", we_k, 2 + dl);
      chk("addr_ok_busy", busy_ok, 0);
      chk("rdata", rd, exp_rd);
      @(negedge clk);
      chk("data_ok_one_cycle", 32'(data_ok[s]), 0);
   endtask

   initial begin
      int idx, ok_k, acc_k, found, cnt;
      logic w;
      logic [1:0] sz;
      logic [31:0] a, wd, old, rd, ed;
      resetn = 1'b0;
      for (int s = 0; s < 2; s++) begin
         req[s] = 0; wr[s] = 0; size[s] = 0; addr[s] = 0; wdata[s] = 0;
      end
      tbl[0]  = '{1, 32'h11223344, 0, 2'd2, 32'h40, 32'h0,        32'h11223344, 32'h0};
      tbl[1]  = '{1, 32'h11223344, 1, 2'd0, 32'h41, 32'h0000AB00, 32'h0,        32'h1122AB44};
      tbl[2]  = '{1, 32'h11223344, 1, 2'd1, 32'h42, 32'hBEEF0000, 32'h0,        32'hBEEF3344};
      tbl[3]  = '{0, 32'h0,        0, 2'd2, 32'h40, 32'h0,        32'hBEEF3344, 32'h0};
      tbl[4]  = '{1, 32'h0,        1, 2'd3, 32'h7C, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
      tbl[5]  = '{1, 32'hAABBCCDD, 1, 2'd0, 32'h43, 32'h77123456, 32'h0,        32'h77BBCCDD};
      tbl[6]  = '{1, 32'hAABBCCDD, 1, 2'd1, 32'h40, 32'hFFFF1234, 32'h0,        32'hAABB1234};
      tbl[7]  = '{1, 32'hAABBCCDD, 1, 2'd1, 32'h41, 32'h00005678, 32'h0,        32'hAABB5678};
      tbl[8]  = '{0, 32'h0,        1, 2'd2, 32'h43, 32'h01020304, 32'h0,        32'h01020304};
      tbl[9]  = '{0, 32'h0,        0, 2'd0, 32'h43, 32'h0,        32'h01020304, 32'h0};
      tbl[10] = '{0, 32'h0,        1, 2'd0, 32'h40, 32'h000000EE, 32'h0,        32'h010203EE};
      tbl[11] = '{1, 32'hCAFEF00D, 0, 2'd1, 32'h7E, 32'h0,        32'hCAFEF00D, 32'h0};
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_addr_ok", 32'(addr_ok[s]), 0);
         chk("rst_data_ok", 32'(data_ok[s]), 0);
         chk("rst_ram_we", 32'(ram_we[s]), 0);
         chk("rst_rdata", rdata[s], 0);
         chk("rst_ram_a", 32'(ram_a[s]), 0);
         chk("rst_ram_d", ram_d[s], 0);
      end
      for (int s = 0; s < 2; s++) for (int i = 0; i < 256; i++) poke(s, i, $urandom);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 12; i++) begin
         idx = int'(tbl[i].addr >> 2) % 256;
         if (tbl[i].init_en) poke(0, idx, tbl[i].init);
         txn(0, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_d);
         if (tbl[i].wr) ref_mem[0][idx] = tbl[i].exp_d;
      end

      // reset asserted while the byte store is in its write cycle
      @(negedge clk);
      poke(0, 16, 32'h11223344);
      req[0] = 1; wr[0] = 1; size[0] = 0; addr[0] = 32'h41; wdata[0] = 32'h0000AB00;
      @(posedge clk);
      #1 req[0] = 0;
      found = 0;
      for (int k = 0; k < 10 && found == 0; k++) begin
         @(negedge clk);
         if (ram_we[0]) found = 1;
      end
      chk("rst_we_reached", found, 1);
      #1 resetn = 1'b0;
      #1;
      chk("rst_mid_ram_we", 32'(ram_we[0]), 0);
      chk("rst_mid_data_ok", 32'(data_ok[0]), 0);
      chk("rst_mid_addr_ok", 32'(addr_ok[0]), 0);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("rst_release_addr_ok", 32'(addr_ok[0]), 1);
      chk("rst_no_write", mem0[16], 32'h11223344);
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (data_ok[0]) cnt++;
      end
      chk("rst_no_response", cnt, 0);
      txn(0, 0, 2'd2, 32'h40, 32'h0, 32'h11223344, 32'h0);

      // DELAY=3 with req held high: second accept only after the response
      @(negedge clk);
      poke(1, 16, 32'h11223344);
      req[1] = 1; wr[1] = 0; size[1] = 2; addr[1] = 32'h40;
      chk("btb_addr_ok", 32'(addr_ok[1]), 1);
      ok_k = 0; acc_k = 0; rd = '0;
      for (int k = 1; k <= 20 && acc_k == 0; k++) begin
         @(negedge clk);
         if (data_ok[1] && ok_k == 0) begin
            ok_k = k;
            rd = rdata[1];
         end
         if (addr_ok[1]) acc_k = k;
      end
      chk("btb_data_ok_latency", ok_k, 5);
      chk("btb_rdata", rd, 32'h11223344);
      chk("btb_second_accept", acc_k, 6);
      @(posedge clk);
      #1 req[1] = 0;
      ok_k = 0;
      for (int k = 1; k <= 20 && ok_k == 0; k++) begin
         @(negedge clk);
         if (data_ok[1]) begin
            ok_k = k;
            rd = rdata[1];
         end
      end
      chk("btb2_data_ok_latency", ok_k, 5);
      chk("btb2_rdata", rd, 32'h11223344);

      for (int i = 0; i < 80; i++) begin
         int s;
         s = i % 4 == 3 ? 1 : 0;
         w = 1'($urandom);
         sz = 2'($urandom);
         a = $urandom;
         wd = $urandom;
         idx = int'(a >> 2) % 256;
         old = ref_mem[s][idx];
         ed = store_model(old, wd, sz, a);
         txn(s, w, sz, a, wd, w ? 32'h0 : old, ed);
         if (w) ref_mem[s][idx] = ed;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
